spi_bus_responder: RTL and testbench

//  SPI responder (mode 0, MSB first): lets an external SPI master read and write the CPU address/data bus.

---
 rtl/spi_bus_responder_if.sv | 28 ++
 rtl/spi_bus_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_bus_responder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_responder_if.sv
// Pin and bus bundle for spi_bus_responder: SPI pins toward the external master
// and the CPU-bus master signals toward the fabric.
interface spi_bus_responder_if #(
  parameter int address_width = 16,
  parameter int data_width    = 8
);
  logic                     sclk_i;
  logic                     cs_ni;
  logic                     mosi_i;
  logic                     miso_o;
  logic                     miso_oe_o;
  logic [address_width-1:0] address_o;
  logic [data_width-1:0]    data_o;
  logic                     we_o;
  logic                     re_o;
  logic [data_width-1:0]    data_i;
  logic                     busy_o;

  modport slave (
    input  sclk_i, cs_ni, mosi_i, data_i,
    output miso_o, miso_oe_o, address_o, data_o, we_o, re_o, busy_o
  );

  modport master (
    output sclk_i, cs_ni, mosi_i, data_i,
    input  miso_o, miso_oe_o, address_o, data_o, we_o, re_o, busy_o
  );
endinterface

// File: rtl/spi_bus_responder.sv
// SPI mode-0 responder that turns CMD/ADDR_HI/ADDR_LO/data frames from an external
// master into single-cycle read and write strobes on the CPU bus.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no frame; waiting for a synchronised cs fall
// ST_CMD     | shifting in the command byte
// ST_ADDR_HI | shifting in address bits 15:8
// ST_ADDR_LO | shifting in address bits 7:0
// ST_WR_DATA | each received byte becomes one bus write
// ST_RD_DATA | each byte shifts out prefetched bus data, then prefetches the next
// ST_IGNORE  | unknown command; idle on the bus until cs rises
module spi_bus_responder #(
  parameter int address_width = 16,
  parameter int data_width    = 8,
  parameter int READ_LATENCY  = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  spi_bus_responder_if.slave   bus
);

  if (data_width != 8) begin : g_bad_data_width
    $error("spi_bus_responder: only data_width = 8 is supported");
  end
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("spi_bus_responder: READ_LATENCY must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [address_width-1:0] ADDR_ONE = 1;

  state_t                    state_q, state_d;
  logic [2:0]                sclk_sync_q, sclk_sync_d;
  logic [2:0]                cs_sync_q, cs_sync_d;
  logic [1:0]                mosi_sync_q, mosi_sync_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                rx_q, rx_d;
  logic [7:0]                tx_q, tx_d;
  logic [7:0]                addr_hi_q, addr_hi_d;
  logic [7:0]                prefetch_q, prefetch_d;
  logic [address_width-1:0]  addr_q, addr_d;
  logic [data_width-1:0]     data_q, data_d;
  logic                      is_read_q, is_read_d;
  logic                      load_pend_q, load_pend_d;
  logic                      we_q, we_d;
  logic                      re_q, re_d;
  logic [READ_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic        byte_done;
  logic [7:0]  rx_byte;
  logic [15:0] addr_full;

  // Edge detection compares sync stage 2 against a third register
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign rx_byte   = {rx_q[6:0], mosi_sync_q[1]};
  assign addr_full = {addr_hi_q, rx_byte};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[1:0], bus.sclk_i};
    cs_sync_d   = {cs_sync_q[1:0], bus.cs_ni};
    mosi_sync_d = {mosi_sync_q[0], bus.mosi_i};
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_hi_d   = addr_hi_q;
    prefetch_d  = prefetch_q;
    addr_d      = addr_q;
    data_d      = data_q;
    is_read_d   = is_read_q;
    load_pend_d = load_pend_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    rd_pipe_d   = rd_pipe_q << 1;
    rd_pipe_d[0] = re_q;

    if (rd_pipe_q[READ_LATENCY-1]) begin
      prefetch_d = bus.data_i;
    end
    // The write strobe cycle uses the current address; step it afterwards
    if (we_q) begin
      addr_d = addr_q + ADDR_ONE;
    end

    if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            if (rx_byte == CMD_WRITE) begin
              is_read_d = 1'b0;
              state_d   = ST_ADDR_HI;
            end else if (rx_byte == CMD_READ) begin
              is_read_d = 1'b1;
              state_d   = ST_ADDR_HI;
            end else begin
              state_d   = ST_IGNORE;
            end
          end
          ST_ADDR_HI: begin
            addr_hi_d = rx_byte;
            state_d   = ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr_d = addr_full[address_width-1:0];
            if (is_read_q) begin
              re_d        = 1'b1;
              load_pend_d = 1'b1;
              state_d     = ST_RD_DATA;
            end else begin
              state_d     = ST_WR_DATA;
            end
          end
          ST_WR_DATA: begin
            data_d = rx_byte;
            we_d   = 1'b1;
          end
          ST_RD_DATA: begin
            addr_d      = addr_q + ADDR_ONE;
            re_d        = 1'b1;
            load_pend_d = 1'b1;
          end
          default: ;
        endcase
      end
      if ((state_q == ST_RD_DATA) && sclk_fall) begin
        if (load_pend_q) begin
          tx_d        = prefetch_q;
          load_pend_d = 1'b0;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end

    if (cs_fall) begin
      bit_cnt_d = 3'd0;
    end
    // cs rise drops any partial byte and suppresses strobes from it
    if (cs_rise) begin
      state_d     = ST_IDLE;
      we_d        = 1'b0;
      re_d        = 1'b0;
      load_pend_d = 1'b0;
      tx_d        = 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_hi_q   <= 8'h00;
      prefetch_q  <= 8'h00;
      addr_q      <= '0;
      data_q      <= '0;
      is_read_q   <= 1'b0;
      load_pend_q <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_hi_q   <= addr_hi_d;
      prefetch_q  <= prefetch_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      is_read_q   <= is_read_d;
      load_pend_q <= load_pend_d;
      we_q        <= we_d;
      re_q        <= re_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign bus.miso_o    = (state_q == ST_RD_DATA) & tx_q[7];
  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.miso_oe_o = (state_q != ST_IDLE);
  assign bus.address_o = addr_q;
  assign bus.data_o    = data_q;
  assign bus.we_o      = we_q;
  assign bus.re_o      = re_q;

endmodule

// File: tb/tb_spi_bus_responder.sv
// Directed bench for spi_bus_responder: SPI master at clk/8, a one-cycle-latency
// bus model returning ~addr[7:0], and a strobe logger checked after each frame.
module tb_spi_bus_responder;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_bus_responder_if #(.address_width(AW), .data_width(DW)) bus_if ();

  spi_bus_responder #(.address_width(AW), .data_width(DW), .READ_LATENCY(1)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus_if)
  );

  int errors = 0;
  int checks = 0;

  // Bus slave: read data appears one cycle after re_o
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_if.data_i <= 8'h00;
    else if (bus_if.re_o) bus_if.data_i <= ~bus_if.address_o[7:0];
  end

  int          we_cnt = 0;
  int          re_cnt = 0;
  int          both_cnt = 0;
  int          miso_nz = 0;
  logic [15:0] we_addr [64];
  logic [7:0]  we_data [64];
  logic [15:0] re_addr [64];

  always @(negedge clk) begin
    if (bus_if.we_o === 1'b1) begin
      we_addr[we_cnt % 64] = bus_if.address_o;
      we_data[we_cnt % 64] = bus_if.data_o;
      we_cnt++;
    end
    if (bus_if.re_o === 1'b1) begin
      re_addr[re_cnt % 64] = bus_if.address_o;
      re_cnt++;
    end
    if (bus_if.we_o === 1'b1 && bus_if.re_o === 1'b1) both_cnt++;
    if (bus_if.miso_o !== 1'b0) miso_nz++;
  end

  logic [7:0] rx_buf [8];
  logic [7:0] tx_buf [8];
  int we_base, re_base, nz_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] val, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus_if.mosi_i = val[7-i];
      wait_clk(4);
      rx = {rx[6:0], bus_if.miso_o};
      bus_if.sclk_i = 1'b1;
      wait_clk(4);
      bus_if.sclk_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus_if.cs_ni = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    bus_if.cs_ni = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bytes(input int n);
    logic [7:0] r;
    for (int k = 0; k < n; k++) begin
      spi_bits(tx_buf[k], 8, r);
      rx_buf[k] = r;
    end
  endtask

  task automatic mark();
    we_base = we_cnt;
    re_base = re_cnt;
    nz_base = miso_nz;
  endtask

  initial begin
    logic [7:0] junk;
    rst_n = 1'b0;
    bus_if.cs_ni = 1'b1;
    bus_if.sclk_i = 1'b0;
    bus_if.mosi_i = 1'b0;
    wait_clk(3);
    check("rst_busy",  {31'd0, bus_if.busy_o}, 32'd0);
    check("rst_oe",    {31'd0, bus_if.miso_oe_o}, 32'd0);
    check("rst_miso",  {31'd0, bus_if.miso_o}, 32'd0);
    check("rst_addr",  {16'd0, bus_if.address_o}, 32'd0);
    check("rst_strb",  {30'd0, bus_if.we_o, bus_if.re_o}, 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // 1: write 02 12 34 AA 55
    mark();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h12; tx_buf[2] = 8'h34; tx_buf[3] = 8'hAA; tx_buf[4] = 8'h55;
    cs_low();
    send_bytes(5);
    check("wr_busy", {31'd0, bus_if.busy_o}, 32'd1);
    cs_high();
    check("wr_cnt",   we_cnt - we_base, 32'd2);
    check("wr_addr0", {16'd0, we_addr[we_base % 64]}, 32'h1234);
    check("wr_data0", {24'd0, we_data[we_base % 64]}, 32'hAA);
    check("wr_addr1", {16'd0, we_addr[(we_base+1) % 64]}, 32'h1235);
    check("wr_data1", {24'd0, we_data[(we_base+1) % 64]}, 32'h55);
    check("wr_no_re", re_cnt - re_base, 32'd0);
    check("wr_miso0", miso_nz - nz_base, 32'd0);

    // 2: read 03 00 10 00 00 00, bus returns ~addr[7:0]
    mark();
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10;
    tx_buf[3] = 8'h00; tx_buf[4] = 8'h00; tx_buf[5] = 8'h00;
    cs_low();
    send_bytes(6);
    cs_high();
    check("rd_rx0", {24'd0, rx_buf[0]}, 32'h00);
    check("rd_rx2", {24'd0, rx_buf[2]}, 32'h00);
    check("rd_rx3", {24'd0, rx_buf[3]}, 32'hEF);
    check("rd_rx4", {24'd0, rx_buf[4]}, 32'hEE);
    check("rd_rx5", {24'd0, rx_buf[5]}, 32'hED);
    check("rd_re0", {16'd0, re_addr[re_base % 64]}, 32'h0010);
    check("rd_re1", {16'd0, re_addr[(re_base+1) % 64]}, 32'h0011);
    check("rd_re2", {16'd0, re_addr[(re_base+2) % 64]}, 32'h0012);
    check("rd_no_we", we_cnt - we_base, 32'd0);

    // 3: address wrap
    mark();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'hFF; tx_buf[2] = 8'hFF; tx_buf[3] = 8'h01; tx_buf[4] = 8'h02;
    cs_low();
    send_bytes(5);
    cs_high();
    check("wrap_cnt",   we_cnt - we_base, 32'd2);
    check("wrap_addr0", {16'd0, we_addr[we_base % 64]}, 32'hFFFF);
    check("wrap_data0", {24'd0, we_data[we_base % 64]}, 32'h01);
    check("wrap_addr1", {16'd0, we_addr[(we_base+1) % 64]}, 32'h0000);
    check("wrap_data1", {24'd0, we_data[(we_base+1) % 64]}, 32'h02);

    // 4: abort mid-byte, then a clean frame
    mark();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h20;
    cs_low();
    send_bytes(3);
    spi_bits(8'hC3, 5, junk);
    wait_clk(2);
    check("abort_oe_before", {31'd0, bus_if.miso_oe_o}, 32'd1);
    bus_if.cs_ni = 1'b1;
    wait_clk(3);
    check("abort_oe_after", {31'd0, bus_if.miso_oe_o}, 32'd0);
    check("abort_busy",     {31'd0, bus_if.busy_o}, 32'd0);
    wait_clk(5);
    check("abort_no_we",    we_cnt - we_base, 32'd0);
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h21; tx_buf[3] = 8'h7E;
    cs_low();
    send_bytes(4);
    cs_high();
    check("abort_next_cnt",  we_cnt - we_base, 32'd1);
    check("abort_next_addr", {16'd0, we_addr[we_base % 64]}, 32'h0021);
    check("abort_next_data", {24'd0, we_data[we_base % 64]}, 32'h7E);

    // 5: unknown command
    mark();
    tx_buf[0] = 8'h07; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h11;
    cs_low();
    send_bytes(4);
    check("bad_busy_in", {31'd0, bus_if.busy_o}, 32'd1);
    cs_high();
    check("bad_busy_out", {31'd0, bus_if.busy_o}, 32'd0);
    check("bad_no_we",    we_cnt - we_base, 32'd0);
    check("bad_no_re",    re_cnt - re_base, 32'd0);
    check("bad_miso",     miso_nz - nz_base, 32'd0);

    // 6: async reset in the middle of a read frame
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h40;
    cs_low();
    send_bytes(3);
    spi_bits(8'h00, 3, junk);
    check("rst_mid_oe_pre",   {31'd0, bus_if.miso_oe_o}, 32'd1);
    check("rst_mid_addr_pre", {16'd0, bus_if.address_o}, 32'h0040);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe",   {31'd0, bus_if.miso_oe_o}, 32'd0);
    check("rst_mid_busy", {31'd0, bus_if.busy_o}, 32'd0);
    check("rst_mid_miso", {31'd0, bus_if.miso_o}, 32'd0);
    check("rst_mid_addr", {16'd0, bus_if.address_o}, 32'd0);
    check("rst_mid_data", {24'd0, bus_if.data_o}, 32'd0);
    check("rst_mid_strb", {30'd0, bus_if.we_o, bus_if.re_o}, 32'd0);
    bus_if.cs_ni = 1'b1;
    bus_if.sclk_i = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    mark();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h50; tx_buf[3] = 8'h5A;
    cs_low();
    send_bytes(4);
    cs_high();
    check("post_rst_cnt",  we_cnt - we_base, 32'd1);
    check("post_rst_addr", {16'd0, we_addr[we_base % 64]}, 32'h0050);
    check("post_rst_data", {24'd0, we_data[we_base % 64]}, 32'h5A);

    check("we_re_overlap", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
